sr_dmem_resp: RTL
=================

SR_DMEM_RESP -- requirements
Module: sr_dmem_resp

Interface
REQ-001 SHALL have parameter DEPTH_WORDS, default 256, number of 32-bit words in the array (power of two, >=4).
REQ-002 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have port dmReq  input  1  access request valid, held stable by the initiator while dmHold=1.
REQ-005 SHALL have port dmWe  input  1  1=store, 0=load.
REQ-006 SHALL have port dmAddr  input  32  byte address.
REQ-007 SHALL have port dmDataW  input  32  store data; the active byte/half is in the low bits.
REQ-008 SHALL have ports op_byte, op_half, op_word  input  1 each  access size.
REQ-009 SHALL have port dmSign  input  1  1=sign-extend sub-word loads, 0=zero-extend.
REQ-010 SHALL have port dmDataR  output  32  load data.
REQ-011 SHALL have port dmHold  output  1  stall request to the initiator, combinational.
REQ-012 SHALL have port dmFault  output  1  misaligned-access pulse, registered.

Function
REQ-013 SHALL hold a DEPTH_WORDS x 32 array with synchronous read; word index = dmAddr[log2(DEPTH_WORDS)+1:2]; upper address bits ignored, so addresses wrap modulo 4*DEPTH_WORDS.
REQ-014 SHALL decode size with priority op_word > op_half > op_byte; a request with no size bit set is a no-op: no write, no hold, no fault.
REQ-015 SHALL treat an access as misaligned when it is a half with dmAddr[0]=1, or a word with dmAddr[1:0]!=0.
REQ-016 SHALL implement FSM states IDLE and LOAD_DONE; IDLE -> LOAD_DONE on a valid aligned load (dmReq & ~dmWe) in IDLE; LOAD_DONE -> IDLE unconditionally after one cycle.
REQ-017 SHALL assert dmHold=1 only in IDLE with a valid aligned load present; dmHold=0 in LOAD_DONE and in every other case.
REQ-018 SHALL drive dmDataR in LOAD_DONE from the registered read word: word = full word; half = lane dmAddr[1] (0 = bits 15:0), extended to 32 bits; byte = lane dmAddr[1:0] (0 = bits 7:0), extended to 32 bits; extension per dmSign.
REQ-019 SHALL drive dmDataR=0 in IDLE, so load latency is 2 cycles: request cycle (held) plus data cycle.
REQ-020 SHALL complete an aligned store in one cycle with no hold, writing only the addressed byte lanes on the clock edge: word = all 4 lanes; half = 2 lanes from dmDataW[15:0]; byte = 1 lane from dmDataW[7:0].
REQ-021 SHALL NOT accept a new request while in LOAD_DONE, so the still-asserted load request is not re-issued.
REQ-022 SHALL, on a misaligned request in IDLE, perform no write and no hold, and pulse dmFault=1 for exactly the following cycle; misaligned loads return dmDataR=0.
REQ-023 SHALL clear dmFault to 0 in any cycle not preceded by a misaligned request.
REQ-024 SHALL leave array contents unchanged by loads, faults and no-ops.

Reset
REQ-025 SHALL, while rst=1, force state=IDLE, dmFault=0 and dmDataR=0 immediately, independent of clk.
REQ-026 SHALL, with dmReq=1 and rst=1, drive dmHold=0, and SHALL NOT write the array while rst=1.
REQ-027 SHALL abort a load on reset asserted during LOAD_DONE: after rst falls, the bench re-issues the load, and the responder returns to IDLE behaviour (hold again, 2-cycle latency).
REQ-028 SHALL NOT initialise or clear array contents on reset.

Verification
REQ-029 SHALL cover word store then load: store word 0xDEADBEEF at addr 0x10 -> next, load word at 0x10 gives dmHold=1 in the request cycle and dmDataR=0xDEADBEEF in the following cycle.
REQ-030 SHALL cover byte loads: after 0xDEADBEEF at 0x10, load byte at 0x13 with dmSign=1 -> 0xFFFFFFDE; same load with dmSign=0 -> 0x000000DE; load half at 0x10 with dmSign=1 -> 0xFFFFBEEF.
REQ-031 SHALL cover a sub-word store: store byte 0x55 at 0x11 over 0xDEADBEEF -> word load at 0x10 returns 0xDEAD55EF.
REQ-032 SHALL cover a misaligned access: store word at 0x12 -> no write (0x10 still 0xDEADBEEF), dmFault=1 for exactly one cycle, dmHold=0.
REQ-033 SHALL cover address wrap: with DEPTH_WORDS=256, store at 0x400 then word load at 0x000 -> the stored value.
REQ-034 SHALL cover reset mid-load: assert rst during LOAD_DONE -> dmDataR=0 immediately and state=IDLE; the re-issued load completes normally with dmHold=1 then valid data.

Source files
------------

// File: rtl/sr_dmem_resp.sv
// Single-port data memory responder: 1-cycle aligned stores, 2-cycle loads (request cycle held + data cycle).
// Backpressure: dmHold stalls the initiator only during the request cycle of a load; misaligned requests raise dmFault.
module sr_dmem_resp #(
   parameter int DEPTH_WORDS = 256
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        dmReq,
   input  logic        dmWe,
   input  logic [31:0] dmAddr,
   input  logic [31:0] dmDataW,
   input  logic        op_byte,
   input  logic        op_half,
   input  logic        op_word,
   input  logic        dmSign,
   output logic [31:0] dmDataR,
   output logic        dmHold,
   output logic        dmFault
);

   localparam int AW = $clog2(DEPTH_WORDS);

   typedef enum logic {
      IDLE      = 1'b0,
      LOAD_DONE = 1'b1
   } state_t;

   typedef struct packed {
      logic       isWord;
      logic       isHalf;
      logic       sign;
      logic [1:0] lane;
   } ldMeta_t;

   state_t        state;
   state_t        stateNxt;
   logic [31:0]   mem [DEPTH_WORDS];
   logic [31:0]   rdWord;
   ldMeta_t       ldMeta;

   logic [AW-1:0] wordIdx;
   logic          unusedAddrHi;
   logic          isWord;
   logic          isHalf;
   logic          isByte;
   logic          misaligned;
   logic          validReq;
   logic          loadGo;
   logic          storeGo;
   logic [3:0]    laneWe;
   logic [31:0]   wrData;

   assign wordIdx      = dmAddr[AW+1:2];
   assign unusedAddrHi = ^dmAddr[31:AW+2];

   // Size priority: word over half over byte; no size bit means no-op.
   assign isWord     = op_word;
   assign isHalf     = ~op_word & op_half;
   assign isByte     = ~op_word & ~op_half & op_byte;
   assign misaligned = (isHalf & dmAddr[0]) | (isWord & (dmAddr[1:0] != 2'b00));

   // Requests are only accepted in IDLE so a load still held in LOAD_DONE is not re-issued.
   assign validReq = dmReq & (isWord | isHalf | isByte) & (state == IDLE) & ~rst;
   assign loadGo   = validReq & ~dmWe & ~misaligned;
   assign storeGo  = validReq & dmWe & ~misaligned;

   always_comb begin
      laneWe = 4'b0000;
      wrData = dmDataW;
      if (isWord) begin
         laneWe = 4'b1111;
      end else if (isHalf) begin
         laneWe = dmAddr[1] ? 4'b1100 : 4'b0011;
         wrData = {2{dmDataW[15:0]}};
      end else if (isByte) begin
         laneWe = 4'b0001 << dmAddr[1:0];
         wrData = {4{dmDataW[7:0]}};
      end
   end

   always_ff @(posedge clk) begin
      if (storeGo) begin
         for (int b = 0; b < 4; b++) begin
            if (laneWe[b]) begin
               mem[wordIdx][8*b +: 8] <= wrData[8*b +: 8];
            end
         end
      end
   end

   // Load attributes are captured with the word so the data cycle does not depend on the initiator.
   always_ff @(posedge clk) begin
      if (loadGo) begin
         rdWord <= mem[wordIdx];
         ldMeta <= '{isWord: isWord, isHalf: isHalf, sign: dmSign, lane: dmAddr[1:0]};
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state   <= IDLE;
         dmFault <= 1'b0;
      end else begin
         state   <= stateNxt;
         dmFault <= validReq & misaligned;
      end
   end

   always_comb begin
      stateNxt = state;
      unique case (state)
         IDLE:      if (loadGo) stateNxt = LOAD_DONE;
         LOAD_DONE: stateNxt = IDLE;
         default:   stateNxt = IDLE;
      endcase
   end

   always_comb begin
      logic [15:0] halfSel;
      logic [7:0]  byteSel;
      dmHold  = loadGo;
      dmDataR = '0;
      halfSel = ldMeta.lane[1] ? rdWord[31:16] : rdWord[15:0];
      byteSel = rdWord[{ldMeta.lane, 3'b000} +: 8];
      if (state == LOAD_DONE) begin
         if (ldMeta.isWord) begin
            dmDataR = rdWord;
         end else if (ldMeta.isHalf) begin
            dmDataR = {{16{ldMeta.sign & halfSel[15]}}, halfSel};
         end else begin
            dmDataR = {{24{ldMeta.sign & byteSel[7]}}, byteSel};
         end
      end
   end

endmodule
